// File: rtl/fifo_sync_buf.sv
// Synchronous FIFO with occupancy count, programmable almost-full/almost-empty levels,
// synchronous flush and sticky overflow/underflow flags; all status is registered.
module fifo_sync_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } stat_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
  logic [CW-1:0]         count_q, count_nxt;
  stat_t                 stat_q, stat_nxt;
  logic                  wr_ok, rd_ok, ov_evt, un_evt;

  // Acceptance uses pre-edge registered flags only, so no wr/rd -> status path exists.
  assign wr_ok  = wr & (~stat_q.full | rd) & ~flush;
  assign rd_ok  = rd & ~stat_q.empty & ~flush;
  assign ov_evt = wr & stat_q.full & ~rd & ~flush;
  assign un_evt = rd & stat_q.empty & ~flush;

  always_comb begin
    count_nxt = count_q;
    if (flush)
      count_nxt = '0;
    else if (wr_ok && !rd_ok)
      count_nxt = count_q + CW'(1);
    else if (rd_ok && !wr_ok)
      count_nxt = count_q - CW'(1);
    stat_nxt.full         = (count_nxt == DEPTH_C);
    stat_nxt.empty        = (count_nxt == '0);
    stat_nxt.almost_full  = (count_nxt >= AF_C);
    stat_nxt.almost_empty = (count_nxt <= AE_C);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count_q   <= '0;
      stat_q    <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        w_ptr <= '0;
        r_ptr <= '0;
      end else begin
        if (wr_ok) w_ptr <= w_ptr + ADDR_WIDTH'(1);
        if (rd_ok) r_ptr <= r_ptr + ADDR_WIDTH'(1);
      end
      count_q   <= count_nxt;
      stat_q    <= stat_nxt;
      // A fresh error beats clr_err in the same cycle.
      overflow  <= ov_evt | (overflow  & ~clr_err);
      underflow <= un_evt | (underflow & ~clr_err);
    end
  end

  // Storage is not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset_n && wr_ok) mem[w_ptr] <= w_data;
  end

  assign r_data       = mem[r_ptr];
  assign count        = count_q;
  assign full         = stat_q.full;
  assign empty        = stat_q.empty;
  assign almost_full  = stat_q.almost_full;
  assign almost_empty = stat_q.almost_empty;
endmodule

// File: tb/tb_fifo_sync_buf.sv
// Directed bench for fifo_sync_buf at DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
module tb_fifo_sync_buf;
  logic       clk = 1'b0;
  logic       reset_n, wr, rd, flush, clr_err;
  logic [7:0] w_data, r_data;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;
  int total = 0;
  int bad   = 0;

  fifo_sync_buf #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .w_data(w_data), .rd(rd), .r_data(r_data),
    .flush(flush), .clr_err(clr_err), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs, clock once, then settle 1 time unit past the edge.
  task automatic step(input logic rst_n_i, input logic wr_i, input logic [7:0] d,
                      input logic rd_i, input logic fl_i, input logic ce_i);
    reset_n = rst_n_i; wr = wr_i; w_data = d; rd = rd_i; flush = fl_i; clr_err = ce_i;
    @(posedge clk);
    #1;
    reset_n = 1'b1; wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  // status vector: {full, empty, almost_full, almost_empty, overflow, underflow}
  task automatic chk_st(input string tag, input logic [2:0] c, input logic [5:0] st);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".flags"}, 32'({full, empty, almost_full, almost_empty, overflow, underflow}), 32'(st));
  endtask

  initial begin
    reset_n = 1'b0; wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0; w_data = 8'h00;
    #2;
    // 1 reset held two cycles with wr asserted
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk_st("reset", 3'd0, 6'b010100);

    // 2 fill
    step(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    chk_st("fill1", 3'd1, 6'b000100);
    chk("fill1.rdata", 32'(r_data), 32'hA1);
    step(1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
    chk_st("fill2", 3'd2, 6'b000000);
    step(1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
    chk_st("fill3", 3'd3, 6'b001000);
    step(1'b1, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
    chk_st("fill4", 3'd4, 6'b101000);
    step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk_st("ovf", 3'd4, 6'b101010);
    chk("ovf.rdata", 32'(r_data), 32'hA1);

    // 3 wr&rd while full
    step(1'b1, 1'b1, 8'hB5, 1'b1, 1'b0, 1'b0);
    chk_st("fullrw", 3'd4, 6'b101010);
    chk("fullrw.rdata", 32'(r_data), 32'hA2);
    chk("drain0", 32'(r_data), 32'hA2);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drain1", 32'(r_data), 32'hA3);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drain2", 32'(r_data), 32'hA4);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drain3", 32'(r_data), 32'hB5);
    chk_st("drain3", 3'd1, 6'b000110);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk_st("drained", 3'd0, 6'b010110);

    // 4 wr&rd while empty
    step(1'b1, 1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
    chk_st("emptyrw", 3'd1, 6'b000111);
    chk("emptyrw.rdata", 32'(r_data), 32'h5C);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_st("clrerr", 3'd1, 6'b000100);

    // 5 flush with wr at count=3, overflow set beforehand
    step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk_st("ovf2", 3'd4, 6'b101010);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk_st("pre_flush", 3'd3, 6'b001010);
    chk("pre_flush.rdata", 32'(r_data), 32'h22);
    step(1'b1, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    chk_st("flush", 3'd0, 6'b010110);
    step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    chk_st("postflush", 3'd1, 6'b000110);
    chk("postflush.rdata", 32'(r_data), 32'h11);
    // flush with rd on a non-empty FIFO: no underflow, rd discarded
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk_st("flushrd", 3'd0, 6'b010110);

    // 6 mid-operation reset at count=2 with wr&rd
    step(1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
    chk_st("pre_rst", 3'd2, 6'b000010);
    step(1'b0, 1'b1, 8'h56, 1'b1, 1'b0, 1'b0);
    chk_st("midrst", 3'd0, 6'b010100);

    // clr_err concurrent with a new underflow: set wins
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk_st("clr_vs_err", 3'd0, 6'b010101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
